// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin owner of the single register-file write port.
// Optional feature: define WARB_LOCK_EN to add req_lock (back-to-back locked writes).
module rf_write_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 16
) (
   input  logic                      clk,
   input  logic                      nRESET,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef WARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        req_lock,
`endif
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      rf_write_enable,
   output logic [ADDR_W-1:0]         rf_write_addr,
   output logic [DATA_W-1:0]         rf_write_data,
   output logic [15:0]               wr_count
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(NUM_REQ - 1);

   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [PTR_W-1:0]   last_q, last_d;

   logic [NUM_REQ-1:0] elig_s;
   logic [PTR_W:0]     pick_s;
   logic               lock_s;
   logic               hit_s;
   logic [PTR_W-1:0]   win_s;

   // First eligible index after 'last', wrapping; MSB of the result flags a hit.
   function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                              input logic [PTR_W-1:0]   last);
      logic [PTR_W:0]   pick;
      logic [PTR_W-1:0] idx;
      pick = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = PTR_W'((int'(last) + k) % NUM_REQ);
         if (elig[idx]) begin
            pick = {1'b1, idx};
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

`ifdef WARB_LOCK_EN
   // A lock only persists while the locked requester won the previous cycle.
   assign lock_s = req_lock[last_q] & req[last_q] & gnt_q[last_q];
`else
   assign lock_s = 1'b0;
`endif

   // Winner selection and next write command.
   always_comb begin
      elig_s = req & ~gnt_q;
      pick_s = rr_pick(elig_s, last_q);
      gnt_d  = '0;
      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      last_d = last_q;
      if (lock_s) begin
         hit_s = 1'b1;
         win_s = last_q;
      end else begin
         hit_s = pick_s[PTR_W];
         win_s = pick_s[PTR_W-1:0];
      end
      if (hit_s) begin
         gnt_d  = onehot(win_s);
         we_d   = 1'b1;
         addr_d = req_addr[int'(win_s)*ADDR_W +: ADDR_W];
         data_d = req_data[int'(win_s)*DATA_W +: DATA_W];
         last_d = win_s;
         cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      end else begin
         gnt_d  = '0;
         we_d   = 1'b0;
      end
   end

   // Registered write command, pointer and counter.
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         gnt_q  <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         cnt_q  <= 16'd0;
         last_q <= LAST_RST;
      end else begin
         gnt_q  <= gnt_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   assign gnt             = gnt_q;
   assign rf_write_enable = we_q;
   assign rf_write_addr   = addr_q;
   assign rf_write_data   = data_q;
   assign wr_count        = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a queue-based reference model predicts each
// cycle's write command; a monitor pops and compares. Lock test only under WARB_LOCK_EN.
module tb_rf_write_arbiter;

   localparam int N  = 3;
   localparam int AW = 3;
   localparam int DW = 16;

   logic              clk    = 1'b0;
   logic              nRESET = 1'b0;
   logic [N-1:0]      req      = '0;
   logic [N*AW-1:0]   req_addr = '0;
   logic [N*DW-1:0]   req_data = '0;
   logic [N-1:0]      lk       = '0;
   logic [N-1:0]      gnt;
   logic              rf_write_enable;
   logic [AW-1:0]     rf_write_addr;
   logic [DW-1:0]     rf_write_data;
   logic [15:0]       wr_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [N-1:0]  gnt;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [15:0]   cnt;
   } exp_t;

   exp_t          sb_q[$];
   logic [DW-1:0] rf_mem [8];
   bit            lock_en;

   rf_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk             (clk),
      .nRESET          (nRESET),
      .req             (req),
      .req_addr        (req_addr),
      .req_data        (req_data),
`ifdef WARB_LOCK_EN
      .req_lock        (lk),
`endif
      .gnt             (gnt),
      .rf_write_enable (rf_write_enable),
      .rf_write_addr   (rf_write_addr),
      .rf_write_data   (rf_write_data),
      .wr_count        (wr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt"},  64'(gnt), 64'd0);
      chk({tag, "_we"},   64'(rf_write_enable), 64'd0);
      chk({tag, "_addr"}, 64'(rf_write_addr), 64'd0);
      chk({tag, "_data"}, 64'(rf_write_data), 64'd0);
      chk({tag, "_cnt"},  64'(wr_count), 64'd0);
   endtask

   // Reference model: searches requesters after the last winner, skipping the
   // one granted in the previous cycle; counts writes up to 65535.
   int            m_last, m_prev, m_w, m_i;
   int unsigned   m_cnt;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   exp_t          m_e;
   initial begin
      m_last = N - 1; m_prev = -1; m_cnt = 0; m_addr = '0; m_data = '0;
      forever begin
         @(posedge clk or negedge nRESET);
         if (!nRESET) begin
            m_last = N - 1; m_prev = -1; m_cnt = 0; m_addr = '0; m_data = '0;
            sb_q.delete();
         end else begin
            m_w = -1;
            if (lock_en && m_prev >= 0 && m_prev == m_last && lk[m_last] && req[m_last])
               m_w = m_last;
            else
               for (int k = 1; k <= N; k++) begin
                  m_i = (m_last + k) % N;
                  if (m_w < 0 && req[m_i] && m_i != m_prev) m_w = m_i;
               end
            m_e.gnt = '0;
            m_e.we  = 1'b0;
            if (m_w >= 0) begin
               m_e.gnt[m_w] = 1'b1;
               m_e.we       = 1'b1;
               m_addr       = req_addr[m_w*AW +: AW];
               m_data       = req_data[m_w*DW +: DW];
               m_last       = m_w;
               if (m_cnt < 65535) m_cnt++;
            end
            m_prev   = m_w;
            m_e.addr = m_addr;
            m_e.data = m_data;
            m_e.cnt  = m_cnt[15:0];
            sb_q.push_back(m_e);
         end
      end
   end

   // Monitor: compares every cycle's outputs against the scoreboard.
   exp_t mon_e;
   initial forever begin
      @(posedge clk);
      #1;
      if (!nRESET) begin
         chk_zero("in_reset");
      end else if (sb_q.size() == 0) begin
         chk("sb_empty", 64'd0, 64'd1);
      end else begin
         mon_e = sb_q.pop_front();
         chk("gnt",  64'(gnt), 64'(mon_e.gnt));
         chk("we",   64'(rf_write_enable), 64'(mon_e.we));
         chk("addr", 64'(rf_write_addr), 64'(mon_e.addr));
         chk("data", 64'(rf_write_data), 64'(mon_e.data));
         chk("cnt",  64'(wr_count), 64'(mon_e.cnt));
         chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
      end
   end

   // Harness register file, written at the end of each write cycle.
   initial forever begin
      @(negedge clk);
      if (nRESET && rf_write_enable) rf_mem[rf_write_addr] = rf_write_data;
   end

   task automatic do_reset();
      @(negedge clk);
      nRESET = 1'b0;
      #1;
      chk_zero("async_reset");
      @(negedge clk);
      @(negedge clk);
      nRESET = 1'b1;
   endtask

   task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic wait_out();
      @(posedge clk);
      #2;
   endtask

   logic [N-1:0] exp_fair [6];
   logic [N-1:0] exp_single [6];

   initial begin
`ifdef WARB_LOCK_EN
      lock_en = 1'b1;
`else
      lock_en = 1'b0;
`endif
      for (int a = 0; a < 8; a++) rf_mem[a] = '0;
      exp_fair   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      exp_single = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000};
      @(negedge clk);
      @(negedge clk);
      nRESET = 1'b1;

      // Single requester held: grant every second cycle.
      do_reset();
      set_slot(1, 3'd5, 16'hBEEF);
      req = 3'b010;
      for (int c = 0; c < 6; c++) begin
         wait_out();
         chk("single_gnt", 64'(gnt), 64'(exp_single[c]));
         if (c == 0) begin
            chk("single_addr", 64'(rf_write_addr), 64'd5);
            chk("single_data", 64'(rf_write_data), 64'hBEEF);
         end
      end
      @(negedge clk);
      req = '0;

      // Fairness: all three held.
      do_reset();
      for (int i = 0; i < N; i++) set_slot(i, 3'(i), 16'(16'h0100 + i));
      req = 3'b111;
      for (int c = 0; c < 6; c++) begin
         wait_out();
         chk("fair_gnt", 64'(gnt), 64'(exp_fair[c]));
      end
      @(negedge clk);
      req = '0;

      // Collision on register 4: later grant wins.
      do_reset();
      set_slot(0, 3'd4, 16'h1111);
      set_slot(2, 3'd4, 16'h2222);
      req = 3'b101;
      wait_out();
      chk("coll_first", 64'(rf_write_data), 64'h1111);
      @(negedge clk);
      req[0] = 1'b0;
      wait_out();
      chk("coll_second", 64'(rf_write_data), 64'h2222);
      @(negedge clk);
      req[2] = 1'b0;
      @(negedge clk);
      #1;
      chk("coll_rf4", 64'(rf_mem[4]), 64'h2222);

      // Idle: command and count hold.
      for (int c = 0; c < 4; c++) wait_out();
      chk("idle_we",   64'(rf_write_enable), 64'd0);
      chk("idle_addr", 64'(rf_write_addr), 64'd4);
      chk("idle_data", 64'(rf_write_data), 64'h2222);
      chk("idle_cnt",  64'(wr_count), 64'd2);

`ifdef WARB_LOCK_EN
      do_reset();
      set_slot(0, 3'd1, 16'hA0A0);
      set_slot(1, 3'd2, 16'hB0B0);
      req = 3'b011;
      lk  = 3'b001;
      for (int c = 0; c < 4; c++) begin
         wait_out();
         chk("lock_gnt", 64'(gnt), 64'd1);
      end
      @(negedge clk);
      lk = '0;
      wait_out();
      chk("lock_release", 64'(gnt), 64'd2);
      @(negedge clk);
      req = '0;
`endif

      // Randomized protocol-respecting traffic with a mid-run reset.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c == 1500) begin
            nRESET = 1'b0;
            #1;
            chk_zero("midrun_reset");
            @(negedge clk);
            nRESET = 1'b1;
         end
         for (int i = 0; i < N; i++) begin
            if (req[i] && gnt[i]) begin
               if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
               else set_slot(i, AW'($urandom), DW'($urandom));
            end else if (!req[i] && $urandom_range(9, 0) < 4) begin
               req[i] = 1'b1;
               set_slot(i, AW'($urandom), DW'($urandom));
            end
         end
      end
      @(negedge clk);
      req = '0;

      // Saturation: keep the port busy past 65535 writes.
      do_reset();
      for (int i = 0; i < N; i++) set_slot(i, 3'(i + 1), 16'(16'h5A00 + i));
      req = 3'b111;
      repeat (65545) @(negedge clk);
      #1;
      chk("sat_cnt", 64'(wr_count), 64'hFFFF);
      repeat (4) @(negedge clk);
      #1;
      chk("sat_hold", 64'(wr_count), 64'hFFFF);
      req = '0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
